a2d_spi_resp: RTL and testbench
===============================

// Module: a2d_spi_resp
// PURPOSE
//  SPI responder modelling the 8-channel 12-bit A2D converter that the A2D interface master polls.
//  Receives a 16-bit command per SS_n-framed transaction; channel = cmd[13:11].
//  Returns the previously addressed channel's result on MISO as {4'b0000, data[11:0]}.
//  Result is pipelined: data returned in transaction N belongs to the channel addressed in N-1.
//  Used as the converter stand-in for system simulation and FPGA loopback; oversampled in clk domain.
// PARAMETERS
//  DATA_W     12  conversion result width; MISO word = {(16-DATA_W) zeros, result}
//  CH_LSB     11  LSB of the 3-bit channel field in the received command
//  MISO_IDLE  1   MISO level driven while SS_n is high
//  INC_STEP   1   offset increment per completed transaction (A2D_RESP_AUTOINC_EN only)
// PORTS
//  clk        in   1    system clock, 50 MHz
//  rst        in   1    asynchronous reset, active-high
//  SS_n       in   1    slave select from master, active-low, asynchronous to clk
//  SCLK       in   1    serial clock from master, idles high, asynchronous to clk
//  MOSI       in   1    command data, stable around SCLK rise
//  MISO       out  1    response data, changes after SCLK fall
//  chan_data  in   96   channel results; ch k = chan_data[12k+11:12k]
//  cmd_vld    out  1    1-clk pulse: full 16-bit command received and committed
//  cmd        out  16   last committed command, held until next commit
//  chnl       out  3    channel used for the next transaction's response (= cmd[CH_LSB+2:CH_LSB])
//  abort      out  1    1-clk pulse: SS_n deasserted before 16 SCLK rises
// BEHAVIOUR
//  - Reset: MISO=MISO_IDLE, cmd_vld=0, cmd=16'h0000, chnl=3'd0, abort=0, state=IDLE, bit_cnt=0.
//  - SS_n, SCLK, MOSI pass through 2-FF synchronizers, then a 3rd flop for edge detect.
//  - Edge flags (ss_fall, ss_rise, sclk_rise, sclk_fall) assert 3 clk after the pin edge.
//  - Master SCLK half-period must be >= 8 clk for correct operation.
//  - FSM states: IDLE, SHIFT, WAIT_SS.
//  - IDLE:
//    - On ss_fall: tx_shreg <= {0, chan_data[chnl]} (snapshot; later chan_data changes ignored).
//    - MISO <= tx_shreg[15]; bit_cnt <= 0; seen_rise <= 0; go to SHIFT.
//  - SHIFT:
//    - sclk_rise: rx_shreg <= {rx_shreg[14:0], MOSI_sync}; bit_cnt++; seen_rise <= 1.
//    - sclk_fall with seen_rise=1: tx_shreg shifts left and MISO <= next bit.
//      The leading fall before the first rise does not shift.
//    - bit_cnt reaches 16: go to WAIT_SS.
//    - ss_rise while bit_cnt<16: pulse abort; cmd/chnl unchanged; MISO=MISO_IDLE; go to IDLE.
//  - WAIT_SS:
//    - Extra SCLK edges are ignored; MISO holds the last bit.
//    - On ss_rise: cmd <= rx_shreg; chnl <= rx_shreg[CH_LSB+2:CH_LSB]; pulse cmd_vld.
//      MISO <= MISO_IDLE; go to IDLE.
//  - Simultaneous ss_rise and the 16th sclk_rise in one clk: sample the bit first, then commit.
//    Treated as a complete transaction, not an abort.
//  - ss_fall while not in IDLE cannot occur without an ss_rise first, so no action is needed.
//  - Command bits other than the channel field are captured into cmd but otherwise ignored.
//  - rst mid-transaction: immediate return to reset values; the partial command is discarded.
// CONFIGURATION
//  A2D_RESP_AUTOINC_EN defined:
//    - 12-bit offset register, reset 0, increases by INC_STEP on every cmd_vld.
//    - Wraps mod 4096.
//    - Returned result = (chan_data[chnl] + offset) mod 4096, taken at snapshot time.
//  A2D_RESP_AUTOINC_EN undefined: no offset register; result = chan_data[chnl] exactly.
// TESTING
//  1 Reset: assert rst -> MISO=1, cmd=0, chnl=0, cmd_vld=0, abort=0.
//  2 ch0=12'hABC, master sends 16'h2000 (ch4) -> MISO returns 16'h0ABC; then cmd_vld, chnl=4.
//  3 ch4=12'h123, next xfer sends 16'h2800 (ch5) -> returns 16'h0123; then chnl=5.
//  4 SS_n raised after 9 SCLK rises -> abort pulse, chnl stays 5; next xfer still returns ch5.
//  5 17 SCLK pulses, cmd 16'h0000 -> extra edge ignored, cmd_vld once, chnl=0.
//  6 AUTOINC_EN, INC_STEP=1, ch0=12'hFFF, after 1 completed xfer -> next ch0 read returns 16'h0000.

Source files
------------

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder standing in for an 8-channel 12-bit A2D converter.
// Latency: pins are synchronized (2 FF + edge flop), so internal edges lag the pins by 3 clk.
// No backpressure: the master owns SCLK/SS_n timing, and the SCLK half-period must be >= 8 clk.
// Optional feature macro: A2D_RESP_AUTOINC_EN adds an offset that increments on each commit.
module a2d_spi_resp #(
  parameter int DATA_W    = 12,
  parameter int CH_LSB    = 11,
  parameter bit MISO_IDLE = 1'b1,
  parameter int INC_STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SS_n,
  input  logic                SCLK,
  input  logic                MOSI,
  output logic                MISO,
  input  logic [8*DATA_W-1:0] chan_data,
  output logic                cmd_vld,
  output logic [15:0]         cmd,
  output logic [2:0]          chnl,
  output logic                abort
);

  localparam int PAD_W = 16 - DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT_SS} state_t;

  state_t      r_state, w_state_nxt;

  logic        r_ss_s1, r_ss_s2, r_ss_s3;
  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        r_mosi_s1, r_mosi_s2;

  logic [15:0] r_tx, w_tx_nxt;
  logic [15:0] r_rx, w_rx_nxt;
  logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic        r_seen, w_seen_nxt;
  logic        r_miso, w_miso_nxt;
  logic [15:0] r_cmd, w_cmd_nxt;
  logic [2:0]  r_chnl, w_chnl_nxt;
  logic        r_cmd_vld, w_cmd_vld_nxt;
  logic        r_abort, w_abort_nxt;

  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic [DATA_W-1:0] w_sel, w_snap;
  logic [15:0] w_rx_tmp;
  logic [4:0]  w_cnt_tmp;

  // Synchronize the asynchronous SPI pins; SS_n/SCLK idle high, so reset them high to avoid false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_s3   <= 1'b1;
      r_sclk_s1 <= 1'b1; r_sclk_s2 <= 1'b1; r_sclk_s3 <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= SS_n;      r_ss_s2   <= r_ss_s1;   r_ss_s3   <= r_ss_s2;
      r_sclk_s1 <= SCLK;      r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= MOSI;      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_ss_fall   =  r_ss_s3   & ~r_ss_s2;
  assign w_ss_rise   = ~r_ss_s3   &  r_ss_s2;
  assign w_sclk_rise = ~r_sclk_s3 &  r_sclk_s2;
  assign w_sclk_fall =  r_sclk_s3 & ~r_sclk_s2;

  // Select the result of the channel addressed by the previous committed command.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < 8; k++) begin
      if (r_chnl == 3'(k)) w_sel = chan_data[k*DATA_W +: DATA_W];
    end
  end

`ifdef A2D_RESP_AUTOINC_EN
  logic [DATA_W-1:0] r_offset;

  // Offset advances once per committed command and wraps naturally at the result width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_offset <= '0;
    else if (w_cmd_vld_nxt) r_offset <= r_offset + DATA_W'(INC_STEP);
  end

  assign w_snap = w_sel + r_offset;
`else
  logic w_unused_inc;
  assign w_unused_inc = (INC_STEP != 0);
  assign w_snap       = w_sel;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath next values; a 16th rise coinciding with ss_rise is sampled, then committed.
  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_bit_cnt_nxt = r_bit_cnt;
    w_seen_nxt    = r_seen;
    w_miso_nxt    = r_miso;
    w_cmd_nxt     = r_cmd;
    w_chnl_nxt    = r_chnl;
    w_cmd_vld_nxt = 1'b0;
    w_abort_nxt   = 1'b0;
    w_rx_tmp      = r_rx;
    w_cnt_tmp     = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_tx_nxt      = {{PAD_W{1'b0}}, w_snap};
          w_miso_nxt    = w_tx_nxt[15];
          w_bit_cnt_nxt = 5'd0;
          w_seen_nxt    = 1'b0;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_sclk_rise) begin
          w_rx_tmp   = {r_rx[14:0], r_mosi_s2};
          w_cnt_tmp  = r_bit_cnt + 5'd1;
          w_seen_nxt = 1'b1;
        end
        // The leading fall before the first rise must not consume a bit.
        if (w_sclk_fall && r_seen) begin
          w_tx_nxt   = {r_tx[14:0], 1'b0};
          w_miso_nxt = r_tx[14];
        end
        w_rx_nxt      = w_rx_tmp;
        w_bit_cnt_nxt = w_cnt_tmp;
        if (w_cnt_tmp == 5'd16) begin
          if (w_ss_rise) begin
            w_cmd_nxt     = w_rx_tmp;
            w_chnl_nxt    = w_rx_tmp[CH_LSB+2:CH_LSB];
            w_cmd_vld_nxt = 1'b1;
            w_miso_nxt    = MISO_IDLE;
            w_state_nxt   = S_IDLE;
          end else begin
            w_state_nxt   = S_WAIT_SS;
          end
        end else if (w_ss_rise) begin
          w_abort_nxt = 1'b1;
          w_miso_nxt  = MISO_IDLE;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_SS: begin
        if (w_ss_rise) begin
          w_cmd_nxt     = r_rx;
          w_chnl_nxt    = r_rx[CH_LSB+2:CH_LSB];
          w_cmd_vld_nxt = 1'b1;
          w_miso_nxt    = MISO_IDLE;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; reset discards any partial command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_seen    <= 1'b0;
      r_miso    <= MISO_IDLE;
      r_cmd     <= '0;
      r_chnl    <= '0;
      r_cmd_vld <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_seen    <= w_seen_nxt;
      r_miso    <= w_miso_nxt;
      r_cmd     <= w_cmd_nxt;
      r_chnl    <= w_chnl_nxt;
      r_cmd_vld <= w_cmd_vld_nxt;
      r_abort   <= w_abort_nxt;
    end
  end

  assign MISO    = r_miso;
  assign cmd     = r_cmd;
  assign chnl    = r_chnl;
  assign cmd_vld = r_cmd_vld;
  assign abort   = r_abort;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Testbench for a2d_spi_resp: SPI master tasks with randomized traffic against a transaction model.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [95:0] chan_data;
  logic        cmd_vld, abort;
  logic [15:0] cmd;
  logic [2:0]  chnl;

  int checks   = 0;
  int failures = 0;
  int n_vld    = 0;
  int n_abort  = 0;

  // Transaction-level model state
  logic [2:0]  m_chnl;
  logic [15:0] m_cmd;
  logic [11:0] m_off;

  always #10 clk = ~clk;

  a2d_spi_resp dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .chan_data(chan_data), .cmd_vld(cmd_vld), .cmd(cmd), .chnl(chnl), .abort(abort)
  );

  // Count the 1-clk pulses.
  always @(negedge clk) begin
    if (cmd_vld) n_vld++;
    if (abort)   n_abort++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] model_word();
    logic [11:0] v;
    v = chan_data[int'(m_chnl)*12 +: 12];
    v = v + m_off;
    return {4'b0000, v};
  endfunction

  function automatic void set_ch(input int k, input logic [11:0] v);
    chan_data[k*12 +: 12] = v;
  endfunction

  task automatic model_reset();
    m_chnl = 3'd0;
    m_cmd  = 16'h0000;
    m_off  = 12'h000;
  endtask

  // One SS_n frame with n SCLK pulses; rx_w returns the first min(n,16) MISO bits.
  task automatic xfer(input logic [15:0] c, input int n, input bit scramble, output logic [15:0] rx_w);
    logic [15:0] exp_w, rx;
    logic [31:0] mask;
    int nb, v0, a0;
    exp_w = model_word();
    v0 = n_vld; a0 = n_abort;
    rx = '0;
    SS_n = 1'b0;
    wait_clk(10);
    if (scramble) chan_data = {$urandom, $urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? c[15-i] : 1'($urandom);
      wait_clk(10);
      SCLK = 1'b1;
      if (i < 16) rx = {rx[14:0], MISO};
      wait_clk(10);
    end
    wait_clk(10);
    SS_n = 1'b1;
    wait_clk(20);
    nb   = (n < 16) ? n : 16;
    mask = (32'd1 << nb) - 32'd1;
    chk("miso_word", {16'h0, rx} & mask, ({16'h0, exp_w} >> (16 - nb)) & mask);
    if (n >= 16) begin
      m_cmd  = c;
      m_chnl = c[13:11];
`ifdef A2D_RESP_AUTOINC_EN
      m_off  = m_off + 12'd1;
`endif
      chk("cmd_vld_cnt", 32'(n_vld - v0), 32'd1);
      chk("abort_cnt",   32'(n_abort - a0), 32'd0);
    end else begin
      chk("cmd_vld_cnt", 32'(n_vld - v0), 32'd0);
      chk("abort_cnt",   32'(n_abort - a0), 32'd1);
    end
    chk("cmd",       {16'h0, cmd}, {16'h0, m_cmd});
    chk("chnl",      {29'h0, chnl}, {29'h0, m_chnl});
    chk("miso_idle", {31'h0, MISO}, 32'd1);
    rx_w = rx;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"},  {31'h0, MISO},    32'd1);
    chk({tag, "_cmd"},   {16'h0, cmd},     32'd0);
    chk({tag, "_chnl"},  {29'h0, chnl},    32'd0);
    chk({tag, "_vld"},   {31'h0, cmd_vld}, 32'd0);
    chk({tag, "_abort"}, {31'h0, abort},   32'd0);
  endtask

  initial begin
    logic [15:0] w;
    int n;
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; chan_data = '0;
    model_reset();
    wait_clk(5);
    chk_reset_outputs("reset");
    rst = 1'b0;
    wait_clk(5);

    // ch0 result returned while addressing ch4
    set_ch(0, 12'hABC);
    xfer(16'h2000, 16, 1'b0, w);
    chk("dir_ch0_word", {16'h0, w}, 32'h0ABC);

    // ch4 result returned while addressing ch5
    set_ch(4, 12'h123);
    xfer(16'h2800, 16, 1'b0, w);
    chk("dir_ch4_word", {16'h0, w}, 32'h0123);

    // abort after 9 rises leaves ch5 selected
    set_ch(5, 12'h5A5);
    xfer(16'h0000, 9, 1'b0, w);
    xfer(16'h0000, 17, 1'b0, w);
    chk("dir_ch5_word", {16'h0, w}, 32'h05A5);
    chk("dir_17_chnl", {29'h0, chnl}, 32'd0);

    // reset in the middle of a frame
    SS_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 3; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(10);
      SCLK = 1'b1; wait_clk(10);
    end
    rst = 1'b1;
    wait_clk(3);
    chk_reset_outputs("midrst");
    SS_n = 1'b1;
    wait_clk(10);
    rst = 1'b0;
    model_reset();
    wait_clk(10);

`ifdef A2D_RESP_AUTOINC_EN
    // offset wraps a full-scale ch0 result to zero after one commit
    set_ch(0, 12'hFFF);
    xfer(16'h0000, 16, 1'b0, w);
    xfer(16'h0000, 16, 1'b0, w);
    chk("autoinc_wrap", {16'h0, w}, 32'h0000);
`endif

    // randomized traffic, with chan_data scrambled after the snapshot
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) n = $urandom_range(1, 15);
      else                           n = $urandom_range(16, 17);
      xfer(16'($urandom), n, 1'($urandom), w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
